// File: rtl/camera_capture.sv
// camera_capture
//   Writer end of the camera-to-VGA framebuffer path. Takes the camera's
//   byte-serial stream (vsync / href / 8-bit data) in the clk_camera domain,
//   assembles RGB565 pixels (first byte [15:8], second byte [7:0]) and drives
//   the camera port of the shared video memory. Capture is frame-granular:
//   a frame is written only if capture_en was high when that frame started
//   (vsync leaving its active level).
//
// Parameters
//   H_ACTIVE   pixels per line written; columns >= H_ACTIVE are dropped
//   V_ACTIVE   lines per frame written; lines  >= V_ACTIVE are dropped
//   VSYNC_POL  active level of cam_vsync (1 = high during vertical blank)
//
// Ports
//   clk_camera      in   camera pixel clock (only clock)
//   rst_n           in   asynchronous active-low reset
//   capture_en      in   capture the next frame; sampled at frame start only
//   cam_vsync       in   camera vertical sync
//   cam_href        in   camera line-valid
//   cam_data[7:0]   in   camera byte
//   camera_hcount   out  column of the pixel being written
//   camera_vcount   out  line of the pixel being written
//   dout_camera     out  assembled pixel
//   mwe_camera      out  one-cycle framebuffer write strobe
//   camera_request  out  high while a frame is being captured
//   frame_done      out  one-cycle pulse when a captured frame ends
//
// Build option
//   CAMERA_TEST_PATTERN_EN  when defined, the pixel value is replaced by eight
//                           vertical colour bars selected by column[9:7];
//                           cam_data is then ignored.

module camera_capture #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        clk_camera,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [9:0]  camera_hcount,
  output logic [9:0]  camera_vcount,
  output logic [15:0] dout_camera,
  output logic        mwe_camera,
  output logic        camera_request,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    BLANK     = 2'd1,
    ACTIVE    = 2'd2,
    SKIP      = 2'd3
  } state_e;

  // 11-bit limits so H_ACTIVE/V_ACTIVE up to 1024 compare correctly
  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic [9:0]  CNT_MAX = 10'd1023;

  state_e      state_q, state_d;
  logic        vs_q, vs_d;
  logic        href_q, href_d;
  logic        phase_q, phase_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  line_q, line_d;
  logic [7:0]  high_q, high_d;
  logic        mwe_q, mwe_d;
  logic [15:0] dout_q, dout_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        done_q, done_d;

  logic        vs_s;
  logic        vs_rise_s;
  logic        vs_fall_s;
  logic        href_fall_s;
  logic        in_range_s;
  logic [15:0] pix_s;

  // Normalised vsync (1 = in vertical blank) and edge detection
  assign vs_s        = (cam_vsync == VSYNC_POL);
  assign vs_rise_s   = vs_s & ~vs_q;
  assign vs_fall_s   = ~vs_s & vs_q;
  assign href_fall_s = ~cam_href & href_q;
  assign in_range_s  = ({1'b0, col_q} < H_LIM) && ({1'b0, line_q} < V_LIM);

`ifdef CAMERA_TEST_PATTERN_EN
  // Colour-bar generator: eight bars, 128 columns each
  always_comb begin
    pix_s = 16'h0000;
    case (col_q[9:7])
      3'd0:    pix_s = 16'hFFFF;
      3'd1:    pix_s = 16'hFFE0;
      3'd2:    pix_s = 16'h07FF;
      3'd3:    pix_s = 16'h07E0;
      3'd4:    pix_s = 16'hF81F;
      3'd5:    pix_s = 16'hF800;
      3'd6:    pix_s = 16'h001F;
      3'd7:    pix_s = 16'h0000;
      default: pix_s = 16'h0000;
    endcase
  end
`else
  // Camera pixel: latched first byte plus the byte present this cycle
  always_comb begin
    pix_s = {high_q, cam_data};
  end
`endif

  // Next-state logic: frame FSM, byte assembly, counters and write strobe
  always_comb begin
    state_d = state_q;
    vs_d    = vs_s;
    href_d  = cam_href;
    phase_d = phase_q;
    col_d   = col_q;
    line_d  = line_q;
    high_d  = high_q;
    mwe_d   = 1'b0;
    dout_d  = dout_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    done_d  = 1'b0;

    case (state_q)
      WAIT_SYNC: begin
        // Only a full blank after reset guarantees we start on a frame boundary
        if (vs_rise_s) begin
          state_d = BLANK;
        end else begin
          state_d = WAIT_SYNC;
        end
      end

      BLANK: begin
        col_d   = 10'd0;
        line_d  = 10'd0;
        phase_d = 1'b0;
        if (vs_fall_s) begin
          state_d = capture_en ? ACTIVE : SKIP;
        end else begin
          state_d = BLANK;
        end
      end

      ACTIVE: begin
        if (vs_rise_s) begin
          // Frame end takes priority over a coincident end of line
          state_d = BLANK;
          done_d  = 1'b1;
        end else if (href_fall_s) begin
          // End of line: drop any dangling odd byte; empty lines do not advance
          phase_d = 1'b0;
          col_d   = 10'd0;
          if ((col_q != 10'd0) && (line_q != CNT_MAX)) begin
            line_d = line_q + 10'd1;
          end else begin
            line_d = line_q;
          end
        end else if (cam_href) begin
          if (!phase_q) begin
            high_d  = cam_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (in_range_s) begin
              mwe_d  = 1'b1;
              dout_d = pix_s;
              hcnt_d = col_q;
              vcnt_d = line_q;
            end else begin
              mwe_d  = 1'b0;
            end
            // Column advances for clipped pixels too, saturating at the top
            if (col_q != CNT_MAX) begin
              col_d = col_q + 10'd1;
            end else begin
              col_d = col_q;
            end
          end
        end else begin
          state_d = ACTIVE;
        end
      end

      SKIP: begin
        if (vs_rise_s) begin
          state_d = BLANK;
        end else begin
          state_d = SKIP;
        end
      end

      default: begin
        state_d = WAIT_SYNC;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_camera or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_SYNC;
      vs_q    <= 1'b0;
      href_q  <= 1'b0;
      phase_q <= 1'b0;
      col_q   <= 10'd0;
      line_q  <= 10'd0;
      high_q  <= 8'd0;
      mwe_q   <= 1'b0;
      dout_q  <= 16'd0;
      hcnt_q  <= 10'd0;
      vcnt_q  <= 10'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_d;
      href_q  <= href_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      line_q  <= line_d;
      high_q  <= high_d;
      mwe_q   <= mwe_d;
      dout_q  <= dout_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      done_q  <= done_d;
    end
  end

  assign camera_hcount  = hcnt_q;
  assign camera_vcount  = vcnt_q;
  assign dout_camera    = dout_q;
  assign mwe_camera     = mwe_q;
  assign frame_done     = done_q;
  assign camera_request = (state_q == ACTIVE);

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture. Frames are described as lists of line byte
// counts; a frame-level model turns each transmitted byte pair into the
// expected (pixel, column, line, cycle) write and each captured frame end
// into an expected frame_done cycle. Observed writes are collected at the
// falling clock edge and compared inside each scenario task.
`timescale 1ns/1ps

module tb_camera_capture;

`ifdef CAMERA_TEST_PATTERN_EN
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
`else
  localparam int H_ACT = 4;
  localparam int V_ACT = 2;
`endif
  localparam bit POL = 1'b1;

  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef struct packed {
    logic [15:0] d;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [31:0] c;
  } strobe_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture_en;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [9:0]  camera_hcount;
  logic [9:0]  camera_vcount;
  logic [15:0] dout_camera;
  logic        mwe_camera;
  logic        camera_request;
  logic        frame_done;

  logic [31:0] cyc = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;

  strobe_t     obs_q[$];
  strobe_t     exp_q[$];
  logic [31:0] obs_done[$];
  logic [31:0] exp_done[$];

  // model state: synced = a blank has been seen since reset
  bit m_synced;
  bit m_capt;
  int m_line;

  camera_capture #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .VSYNC_POL(POL)) dut (
    .clk_camera(clk), .rst_n(rst_n), .capture_en(capture_en),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .camera_hcount(camera_hcount), .camera_vcount(camera_vcount),
    .dout_camera(dout_camera), .mwe_camera(mwe_camera),
    .camera_request(camera_request), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // collect writes and frame-end pulses
  always @(negedge clk) begin
    if (mwe_camera === 1'b1)
      obs_q.push_back('{d: dout_camera, h: camera_hcount, v: camera_vcount, c: cyc});
    if (frame_done === 1'b1)
      obs_done.push_back(cyc);
  end

  function automatic logic [15:0] model_pix(int px, logic [7:0] hi, logic [7:0] lo);
`ifdef CAMERA_TEST_PATTERN_EN
    return BARS[px / 128];
`else
    return {hi, lo};
`endif
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_queues();
    obs_q.delete(); exp_q.delete(); obs_done.delete(); exp_done.delete();
  endtask

  // enter vertical blank
  task automatic vs_on();
    @(negedge clk);
    cam_vsync = POL;
    if (m_capt) exp_done.push_back(cyc + 32'd1);
    m_capt = 1'b0;
    m_synced = 1'b1;
    m_line = 0;
    tick(3);
  endtask

  // leave vertical blank, i.e. start a frame
  task automatic vs_off(bit en);
    @(negedge clk);
    cam_vsync = !POL;
    capture_en = en;
    m_capt = en && m_synced;
    m_line = 0;
    tick(2);
  endtask

  // one href-high burst of nbytes; rst_at >= 0 pulses reset before that byte
  task automatic send_line(int nbytes, bit rnd, logic [7:0] base, int rst_at);
    logic [7:0] b;
    logic [7:0] hi;
    int px;
    hi = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      if (i == rst_at) begin
        rst_n = 1'b0;
        m_capt = 1'b0;
        m_synced = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      b = rnd ? 8'($urandom) : base + 8'(i * 17);
      cam_href = 1'b1;
      cam_data = b;
      if (i % 2 == 0) begin
        hi = b;
      end else if (m_capt) begin
        px = i / 2;
        if (px < H_ACT && m_line < V_ACT)
          exp_q.push_back('{d: model_pix(px, hi, b), h: 10'(px), v: 10'(m_line), c: cyc + 32'd1});
      end
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'($urandom);
    tick(3);
    if (nbytes >= 2 && m_capt) m_line++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; capture_en = 1'b0; cam_vsync = !POL; cam_href = 1'b0; cam_data = 8'h00;
    m_synced = 1'b0; m_capt = 1'b0; m_line = 0;
    tick(3);
    n_vec++; if (mwe_camera !== 1'b0) begin n_err++; $display("FAIL reset mwe: got %b want 0", mwe_camera); end
    n_vec++; if (dout_camera !== 16'h0000) begin n_err++; $display("FAIL reset dout: got %h want 0000", dout_camera); end
    n_vec++; if (camera_hcount !== 10'd0) begin n_err++; $display("FAIL reset hcount: got %0d want 0", camera_hcount); end
    n_vec++; if (camera_vcount !== 10'd0) begin n_err++; $display("FAIL reset vcount: got %0d want 0", camera_vcount); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
    n_vec++; if (camera_request !== 1'b0) begin n_err++; $display("FAIL reset request: got %b want 0", camera_request); end
    rst_n = 1'b1;
    tick(2);
    // a frame start without a preceding blank must not capture
    vs_off(1'b1);
    n_vec++; if (camera_request !== 1'b0) begin n_err++; $display("FAIL reset no-sync request: got %b want 0", camera_request); end
    vs_on();
  endtask

  task automatic test_full_frame();
    clear_queues();
    n_vec++; if (camera_request !== 1'b0) begin n_err++; $display("FAIL full_frame blank request: got %b want 0", camera_request); end
    vs_off(1'b1);
    n_vec++; if (camera_request !== 1'b1) begin n_err++; $display("FAIL full_frame active request: got %b want 1", camera_request); end
    send_line(8, 1'b0, 8'hA1, -1);
    send_line(8, 1'b1, 8'h00, -1);
    vs_on();
    n_vec++; if (camera_request !== 1'b0) begin n_err++; $display("FAIL full_frame end request: got %b want 0", camera_request); end
`ifndef CAMERA_TEST_PATTERN_EN
    n_vec++;
    if (obs_q.size() < 1 || obs_q[0].d !== 16'hA1B2 || obs_q[0].h !== 10'd0 || obs_q[0].v !== 10'd0) begin
      n_err++; $display("FAIL full_frame first pixel: got %0d strobes, want A1B2 at 0,0", obs_q.size());
    end
`endif
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL full_frame strobe count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL full_frame strobe %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (obs_done.size() !== exp_done.size()) begin n_err++; $display("FAIL full_frame done count: got %0d want %0d", obs_done.size(), exp_done.size()); end
    for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++) begin
      n_vec++; if (obs_done[i] !== exp_done[i]) begin n_err++; $display("FAIL full_frame done cycle: got %0d want %0d", obs_done[i], exp_done[i]); end
    end
  endtask

  task automatic test_skip();
    clear_queues();
    vs_off(1'b0);
    n_vec++; if (camera_request !== 1'b0) begin n_err++; $display("FAIL skip request: got %b want 0", camera_request); end
    capture_en = 1'b1;
    send_line(8, 1'b1, 8'h00, -1);
    send_line(6, 1'b1, 8'h00, -1);
    vs_on();
    n_vec++; if (obs_q.size() !== 0 || obs_done.size() !== 0) begin n_err++; $display("FAIL skip activity: got %0d strobes %0d done want 0 0", obs_q.size(), obs_done.size()); end
    clear_queues();
    vs_off(1'b1);
    send_line(8, 1'b1, 8'h00, -1);
    send_line(4, 1'b1, 8'h00, -1);
    vs_on();
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL skip_next strobe count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL skip_next strobe %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (obs_done.size() !== exp_done.size() || (obs_done.size() > 0 && obs_done[0] !== exp_done[0])) begin
      n_err++; $display("FAIL skip_next done: got %0d pulses want %0d", obs_done.size(), exp_done.size());
    end
  endtask

  task automatic test_clip();
    clear_queues();
    vs_off(1'b1);
    for (int l = 0; l < 3; l++) send_line(12, 1'b1, 8'h00, -1);
    vs_on();
`ifndef CAMERA_TEST_PATTERN_EN
    n_vec++; if (obs_q.size() !== 8) begin n_err++; $display("FAIL clip strobe total: got %0d want 8", obs_q.size()); end
`endif
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL clip strobe count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL clip strobe %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (obs_done.size() !== 1) begin n_err++; $display("FAIL clip done count: got %0d want 1", obs_done.size()); end
  endtask

  task automatic test_odd_bytes();
    clear_queues();
    vs_off(1'b1);
    send_line(5, 1'b1, 8'h00, -1);
    send_line(1, 1'b1, 8'h00, -1);
    send_line(8, 1'b1, 8'h00, -1);
    vs_on();
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL odd strobe count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL odd strobe %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    vs_off(1'b1);
    send_line(8, 1'b1, 8'h00, 3);
    n_vec++; if (mwe_camera !== 1'b0 || camera_request !== 1'b0) begin n_err++; $display("FAIL rst_mid ctrl: got mwe %b req %b want 0 0", mwe_camera, camera_request); end
    n_vec++; if (dout_camera !== 16'h0000 || camera_hcount !== 10'd0 || camera_vcount !== 10'd0) begin
      n_err++; $display("FAIL rst_mid data: got %h %0d %0d want 0000 0 0", dout_camera, camera_hcount, camera_vcount);
    end
    send_line(8, 1'b1, 8'h00, -1);
    vs_on();
    vs_off(1'b1);
    send_line(6, 1'b1, 8'h00, -1);
    send_line(8, 1'b1, 8'h00, -1);
    vs_on();
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rst_mid strobe count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rst_mid strobe %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (obs_done.size() !== exp_done.size() || (obs_done.size() > 0 && obs_done[0] !== exp_done[0])) begin
      n_err++; $display("FAIL rst_mid done: got %0d pulses want %0d", obs_done.size(), exp_done.size());
    end
  endtask

  task automatic test_long_line();
    clear_queues();
    vs_off(1'b1);
    send_line(2048, 1'b1, 8'h00, -1);
    vs_on();
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL long strobe count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL long strobe %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
`ifdef CAMERA_TEST_PATTERN_EN
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].h == 10'd0) begin
        n_vec++; if (obs_q[i].d !== 16'hFFFF) begin n_err++; $display("FAIL bar h0: got %h want FFFF", obs_q[i].d); end
      end else if (obs_q[i].h == 10'd128) begin
        n_vec++; if (obs_q[i].d !== 16'hFFE0) begin n_err++; $display("FAIL bar h128: got %h want FFE0", obs_q[i].d); end
      end else if (obs_q[i].h == 10'd512) begin
        n_vec++; if (obs_q[i].d !== 16'hF81F) begin n_err++; $display("FAIL bar h512: got %h want F81F", obs_q[i].d); end
      end
    end
    n_vec++; if (obs_q.size() == 0 || obs_q[obs_q.size()-1].h !== 10'd639) begin n_err++; $display("FAIL bar last column: got %0d strobes want last at 639", obs_q.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_skip();
    test_clip();
    test_odd_bytes();
    test_reset_mid();
    test_long_line();
    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
